// File: rtl/nth_bit_iter_if.sv
// Load/beat handshake bundle for the set-bit iterator.
// The slave modport is the iterator; the master modport is its producer/consumer.
interface nth_bit_iter_if #(
    parameter int unsigned WIDTH = 12
);
    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             load_valid_i;
    logic             load_ready_o;
    logic [WIDTH-1:0] vec_i;
    logic [CW-1:0]    skip_i;
    logic             abort_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_onehot_o;
    logic [IW-1:0]    out_idx_o;
    logic [CW-1:0]    out_ord_o;
    logic             out_last_o;
    logic             out_empty_o;

    modport slave (
        input  load_valid_i, vec_i, skip_i, abort_i, out_ready_i,
        output load_ready_o, out_valid_o, out_onehot_o, out_idx_o, out_ord_o,
               out_last_o, out_empty_o
    );

    modport master (
        output load_valid_i, vec_i, skip_i, abort_i, out_ready_i,
        input  load_ready_o, out_valid_o, out_onehot_o, out_idx_o, out_ord_o,
               out_last_o, out_empty_o
    );
endinterface

// File: rtl/nth_bit_iter.sv
// Sequential set-bit iterator: discards the lowest skip_i set bits of a loaded
// vector, then emits each remaining set bit LSB-first, one beat per handshake.
module nth_bit_iter #(
    parameter int unsigned WIDTH = 12
) (
    input  logic           clk,
    input  logic           reset_n,
    nth_bit_iter_if.slave  bus
);
    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StSkip, StEmit} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] residue_q, residue_d;
    logic [CW-1:0]    skip_cnt_q, skip_cnt_d;
    logic [CW-1:0]    ord_cnt_q, ord_cnt_d;

    logic [WIDTH-1:0] lowest;
    logic [WIDTH-1:0] res_clr;
    logic [CW-1:0]    skip_dec;
    logic             res_zero;
    logic             res_single;
    logic             emit;
    logic [IW-1:0]    low_idx;

    assign lowest     = residue_q & (~residue_q + WIDTH'(1));
    assign res_clr    = residue_q & (residue_q - WIDTH'(1));
    assign res_zero   = (residue_q == '0);
    assign res_single = !res_zero && (res_clr == '0);
    assign skip_dec   = skip_cnt_q - CW'(1);
    assign emit       = (state_q == StEmit);

    always_comb begin
        state_d    = state_q;
        residue_d  = residue_q;
        skip_cnt_d = skip_cnt_q;
        ord_cnt_d  = ord_cnt_q;
        unique case (state_q)
            StIdle: begin
                // abort_i is ignored here so a coincident load still lands
                if (bus.load_valid_i) begin
                    residue_d  = bus.vec_i;
                    skip_cnt_d = bus.skip_i;
                    ord_cnt_d  = '0;
                    state_d    = (bus.skip_i == '0 || bus.vec_i == '0) ? StEmit : StSkip;
                end
            end
            StSkip: begin
                residue_d  = res_clr;
                skip_cnt_d = skip_dec;
                ord_cnt_d  = ord_cnt_q + CW'(1);
                if (skip_dec == '0 || res_clr == '0) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (bus.out_ready_i) begin
                    residue_d = res_clr;
                    ord_cnt_d = ord_cnt_q + CW'(1);
                    if (res_zero || res_single) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (bus.abort_i && state_q != StIdle) begin
            state_d   = StIdle;
            residue_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            residue_q  <= '0;
            skip_cnt_q <= '0;
            ord_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            residue_q  <= residue_d;
            skip_cnt_q <= skip_cnt_d;
            ord_cnt_q  <= ord_cnt_d;
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lowest[i]) begin
                low_idx = IW'(i);
            end
        end
    end

    // Beat fields are forced to zero outside EMIT so idle outputs stay quiet.
    assign bus.load_ready_o = (state_q == StIdle);
    assign bus.out_valid_o  = emit;
    assign bus.out_onehot_o = emit ? lowest : '0;
    assign bus.out_idx_o    = emit ? low_idx : '0;
    assign bus.out_ord_o    = emit ? ord_cnt_q : '0;
    assign bus.out_last_o   = emit && (res_zero || res_single);
    assign bus.out_empty_o  = emit && res_zero;
endmodule

// File: tb/tb_nth_bit_iter.sv
// Randomised bench for nth_bit_iter: each load is expanded by a list-based
// model into the expected beat sequence and compared beat by beat.
module tb_nth_bit_iter;
    localparam int unsigned WIDTH = 12;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    nth_bit_iter_if #(.WIDTH(WIDTH)) bus ();

    nth_bit_iter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low for the first 3 samples
    task automatic run_load(input logic [WIDTH-1:0] vec, input int skip, input int mode,
                            input bit abort_with_load);
        int set_idx[$];
        int pop, lat, nbeats, bi, guard, cyc, stalls;
        bit empty, rdy;
        int e_idx;
        for (int i = 0; i < WIDTH; i++) if (vec[i]) set_idx.push_back(i);
        pop    = set_idx.size();
        lat    = (skip < pop) ? skip : pop;
        empty  = (pop == lat);
        nbeats = empty ? 1 : pop - lat;

        check_eq("ready_before_load", 32'(bus.load_ready_o), 32'd1);
        bus.load_valid_i = 1'b1;
        bus.vec_i        = vec;
        bus.skip_i       = 4'(skip);
        bus.abort_i      = abort_with_load;
        bus.out_ready_i  = 1'b0;
        step();
        bus.load_valid_i = 1'b0;
        bus.abort_i      = 1'b0;

        cyc = 0;
        while (!bus.out_valid_o && cyc < 40) begin
            check_eq("busy_not_ready", 32'(bus.load_ready_o), 32'd0);
            step();
            cyc++;
        end
        check_eq("latency", 32'(cyc), 32'(lat));

        bi = 0;
        guard = 0;
        stalls = 0;
        while (bi < nbeats && guard < 200) begin
            e_idx = empty ? 0 : set_idx[lat + bi];
            check_eq("valid", 32'(bus.out_valid_o), 32'd1);
            check_eq("idx", 32'(bus.out_idx_o), 32'(e_idx));
            check_eq("onehot", 32'(bus.out_onehot_o), empty ? 32'd0 : (32'd1 << e_idx));
            check_eq("ord", 32'(bus.out_ord_o), 32'(lat + bi));
            check_eq("last", 32'(bus.out_last_o), 32'(bi == nbeats - 1));
            check_eq("empty", 32'(bus.out_empty_o), 32'(empty));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (stalls >= 3);
            endcase
            if (!rdy) stalls++;
            bus.out_ready_i = rdy;
            step();
            guard++;
            if (rdy) bi++;
        end
        check_eq("beats_done", 32'(bi), 32'(nbeats));
        bus.out_ready_i = 1'b0;
        check_eq("valid_after_last", 32'(bus.out_valid_o), 32'd0);
        check_eq("ready_after_last", 32'(bus.load_ready_o), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.load_ready_o), 32'd1);
        check_eq({tag, "_valid"}, 32'(bus.out_valid_o), 32'd0);
        check_eq({tag, "_onehot"}, 32'(bus.out_onehot_o), 32'd0);
        check_eq({tag, "_idx"}, 32'(bus.out_idx_o), 32'd0);
        check_eq({tag, "_ord"}, 32'(bus.out_ord_o), 32'd0);
        check_eq({tag, "_last"}, 32'(bus.out_last_o), 32'd0);
        check_eq({tag, "_empty"}, 32'(bus.out_empty_o), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        bus.load_valid_i = 1'b0;
        bus.vec_i        = '0;
        bus.skip_i       = '0;
        bus.abort_i      = 1'b0;
        bus.out_ready_i  = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();

        run_load(12'b0000_0000_0011, 1, 0, 1'b0);
        step();
        run_load(12'b1000_0101_0100, 0, 0, 1'b0);
        run_load(12'b0, 0, 0, 1'b0);
        run_load(12'b0000_1000_1000, 0, 2, 1'b0);
        run_load(12'b0000_0010_0001, 3, 0, 1'b0);
        run_load(12'b0000_0010_0001, 1, 0, 1'b0);
        run_load(12'b1111_1111_1111, 15, 1, 1'b0);
        run_load(12'b1010_0000_0001, 12, 1, 1'b0);
        run_load(12'b0110_0000_1000, 2, 1, 1'b1);

        // Abort mid-EMIT, with a beat handshaken in the same cycle
        bus.load_valid_i = 1'b1;
        bus.vec_i        = 12'b1000_0101_0100;
        bus.skip_i       = '0;
        step();
        bus.load_valid_i = 1'b0;
        bus.out_ready_i  = 1'b1;
        check_eq("abort_pre_idx2", 32'(bus.out_idx_o), 32'd2);
        step();
        check_eq("abort_pre_idx4", 32'(bus.out_idx_o), 32'd4);
        bus.abort_i = 1'b1;
        step();
        bus.abort_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        check_idle("abort");
        run_load(12'b0001_0010_0100, 1, 1, 1'b0);

        // Asynchronous reset mid-EMIT
        bus.load_valid_i = 1'b1;
        bus.vec_i        = 12'b1000_0101_0100;
        bus.skip_i       = '0;
        step();
        bus.load_valid_i = 1'b0;
        bus.out_ready_i  = 1'b1;
        step();
        check_eq("rst_pre_idx4", 32'(bus.out_idx_o), 32'd4);
        bus.out_ready_i = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        step();

        for (int n = 0; n < 60; n++) begin
            v = WIDTH'($urandom);
            if (n % 3 == 0) v = v & WIDTH'($urandom);
            if (n % 11 == 0) v = '0;
            run_load(v, int'($urandom_range(0, 15)), 1, 1'(n % 7 == 0));
            if (n % 2 == 0) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
